// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: fetch sequencer between the combinational instruction memory
// and the IF/ID register. Owns the PC, prefetches {pc, word} pairs into a small
// FIFO and presents the FIFO head to decode over a valid/ready handshake.
// Branch/jump redirects flush the FIFO and reload the PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect -> HALT + trap).
module im_fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_data,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_busy
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              trap
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t            state_r;
    logic              fetch_busy_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [DATA_W-1:0] instr_mem_r [DEPTH];
    logic [ADDR_W-1:0] pcq_mem_r   [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_next_s;
    logic [PW-1:0]     wr_ptr_next_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_left_s;
    logic [CW-1:0]     count_next_s;
    logic              pop_s;
    logic              push_s;
    logic              misalign_s;
    logic [ADDR_W-1:0] target_s;
    logic              head_valid_s;
    logic [DATA_W-1:0] head_instr_s;
    logic [ADDR_W-1:0] head_pc_s;
    logic              if_valid_r;
    logic [DATA_W-1:0] if_instr_r;
    logic [ADDR_W-1:0] if_pc_r;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic              trap_r;
    assign misalign_s = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign trap       = trap_r;
`else
    assign misalign_s = 1'b0;
`endif

    // Redirect targets are always word aligned when loaded into the PC.
    assign target_s   = redirect_pc & ALIGN_MASK;
    assign im_addr    = pc_r;
    assign if_valid   = if_valid_r;
    assign if_instr   = if_instr_r;
    assign if_pc      = if_pc_r;
    assign fetch_busy = fetch_busy_r;

    // Next-state of PC and FIFO bookkeeping, plus the head entry seen after the edge.
    always_comb begin
        pop_s         = if_valid_r && id_ready;
        count_left_s  = pop_s ? (count_r - CW'(1)) : count_r;
        push_s        = (state_r == ST_RUN) && fetch_en && !redirect_valid &&
                        ((count_r < CW'(DEPTH)) || pop_s);
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        pc_next_s     = pc_r;
        if (redirect_valid) begin
            // A same-cycle pop is simply absorbed by the flush.
            rd_ptr_next_s = '0;
            wr_ptr_next_s = '0;
            count_next_s  = '0;
            if ((state_r != ST_HALT) && !misalign_s) begin
                pc_next_s = target_s;
            end else begin
                pc_next_s = pc_r;
            end
        end else begin
            rd_ptr_next_s = pop_s  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
            wr_ptr_next_s = push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            count_next_s  = push_s ? (count_left_s + CW'(1)) : count_left_s;
            pc_next_s     = push_s ? (pc_r + PC_STEP) : pc_r;
        end

        head_valid_s = 1'b0;
        head_instr_s = '0;
        head_pc_s    = '0;
        if (count_next_s == '0) begin
            head_valid_s = 1'b0;
        end else if (count_left_s == '0) begin
            // FIFO would be empty after the pop: the new head is the word being pushed.
            head_valid_s = 1'b1;
            head_instr_s = im_data;
            head_pc_s    = pc_r;
        end else begin
            head_valid_s = 1'b1;
            head_instr_s = instr_mem_r[rd_ptr_next_s];
            head_pc_s    = pcq_mem_r[rd_ptr_next_s];
        end
    end

    // Fetch control FSM with registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fetch_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (misalign_s) begin
                        state_r      <= ST_HALT;
                        fetch_busy_r <= 1'b0;
                    end else if (fetch_en) begin
                        state_r      <= ST_RUN;
                        fetch_busy_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        fetch_busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (misalign_s) begin
                        state_r      <= ST_HALT;
                        fetch_busy_r <= 1'b0;
                    end else if (!fetch_en) begin
                        state_r      <= ST_IDLE;
                        fetch_busy_r <= 1'b0;
                    end else begin
                        state_r      <= ST_RUN;
                        fetch_busy_r <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_r      <= ST_HALT;
                    fetch_busy_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    fetch_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // PC, FIFO storage/pointers and registered head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            if_valid_r <= 1'b0;
            if_instr_r <= '0;
            if_pc_r    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= '0;
                pcq_mem_r[i]   <= '0;
            end
        end else begin
            pc_r       <= pc_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            wr_ptr_r   <= wr_ptr_next_s;
            count_r    <= count_next_s;
            if_valid_r <= head_valid_s;
            if_instr_r <= head_instr_s;
            if_pc_r    <= head_pc_s;
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= im_data;
                pcq_mem_r[wr_ptr_r]   <= pc_r;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky trap flag: set by a misaligned redirect, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else begin
            trap_r <= trap_r | misalign_s;
        end
    end
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Testbench for im_fetch_ctrl: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the fetch FIFO.
module tb_im_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [7:0]  im_addr;
    logic [31:0] im_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        fetch_busy;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap;
`endif

    logic [31:0] im_mem [64];
    assign im_data = im_mem[im_addr[7:2]];

    always #5 clk = ~clk;

    im_fetch_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_busy     (fetch_busy)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .trap           (trap)
`endif
    );

    // Reference model: queue of {pc, instr}, PC, run/halt flags.
    logic [39:0] mq [$];
    logic [7:0]  m_pc;
    bit          m_run;
    bit          m_halt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("im_addr", im_addr, m_pc);
        check_val("if_valid", if_valid, (mq.size() > 0));
        if (mq.size() > 0) begin
            check_val("if_pc", if_pc, mq[0][39:32]);
            check_val("if_instr", if_instr, mq[0][31:0]);
        end
        check_val("fetch_busy", fetch_busy, m_run);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("trap", trap, m_halt);
`endif
    endtask

    task automatic model_step();
        bit pop;
        bit push;
        bit mis;
        pop = (mq.size() > 0) && id_ready;
        mis = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif
        if (redirect_valid) begin
            mq.delete();
            if (!m_halt) begin
                if (mis) begin
                    m_halt = 1'b1;
                    m_run  = 1'b0;
                end else begin
                    m_pc = redirect_pc & 8'hFC;
                end
            end
        end else begin
            push = m_run && fetch_en && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, im_mem[m_pc[7:2]]});
                m_pc = m_pc + 8'd4;
            end
        end
        if (!m_halt) m_run = fetch_en;
    endtask

    task automatic step(input bit fe, input bit rdy, input bit rv, input logic [7:0] rpc);
        fetch_en       = fe;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        fetch_en       = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        mq.delete();
        m_pc   = 8'h00;
        m_run  = 1'b0;
        m_halt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        check_val("rst_if_instr", if_instr, 40'h0);
        check_val("rst_if_pc", if_pc, 40'h0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] rpc;
        for (int i = 0; i < 64; i++) im_mem[i] = $urandom;
        im_mem[0]  = 32'h20100000;
        im_mem[1]  = 32'h20110000;
        im_mem[4]  = 32'h12280004;
        im_mem[63] = 32'h00000000;

        // Basic fetch from reset
        do_reset();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t1_pc0", if_pc, 40'h00);
        check_val("t1_instr0", if_instr, 40'h20100000);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t1_pc1", if_pc, 40'h04);
        check_val("t1_instr1", if_instr, 40'h20110000);

        // Backpressure fills the FIFO, then drains in order
        do_reset();
        repeat (6) step(1'b1, 1'b0, 1'b0, 8'h00);
        check_val("t2_pc_hold", im_addr, 40'h08);
        check_val("t2_head0", if_pc, 40'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t2_head1", if_pc, 40'h04);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t2_head2", if_pc, 40'h08);

        // Redirect with entries pending
        step(1'b1, 1'b0, 1'b1, 8'h10);
        check_val("t3_bubble", if_valid, 40'h0);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t3_target_pc", if_pc, 40'h10);
        check_val("t3_target_instr", if_instr, 40'h12280004);
        step(1'b1, 1'b1, 1'b0, 8'h00);

        // Redirect to top of memory, PC wraps
        step(1'b1, 1'b1, 1'b1, 8'hFC);
        check_val("t4_bubble", if_valid, 40'h0);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t4_pc_fc", if_pc, 40'hFC);
        check_val("t4_instr_fc", if_instr, 40'h0);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t4_pc_00", if_pc, 40'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t4_pc_04", if_pc, 40'h04);

        // Asynchronous reset with a full FIFO
        repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00);
        check_val("t5_full", if_valid, 40'h1);
        rst = 1'b1;
        #1;
        check_val("t5_async_valid", if_valid, 40'h0);
        check_val("t5_async_instr", if_instr, 40'h0);
        check_val("t5_async_pc", if_pc, 40'h0);
        check_val("t5_async_busy", fetch_busy, 40'h0);
        check_val("t5_async_addr", im_addr, 40'h0);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t5_restart_pc", if_pc, 40'h00);

        // Misaligned redirect
        step(1'b1, 1'b1, 1'b1, 8'h12);
        check_val("t6_bubble", if_valid, 40'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("t6_trap", trap, 40'h1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h20);
        check_val("t6_stuck_valid", if_valid, 40'h0);
        check_val("t6_stuck_trap", trap, 40'h1);
        do_reset();
`else
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("t6_aligned_pc", if_pc, 40'h10);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rpc = 8'($urandom);
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc[1:0] = 2'b00;
`endif
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
